// File: rtl/axis_frame_arbiter.sv
// Frame-granular AXI-Stream arbiter: a source keeps the grant until its tlast beat is accepted.
// Optional per-frame beat limit is enabled by defining AXIS_ARB_MAXBEAT_EN.
module axis_frame_arbiter #(
  parameter int unsigned S_COUNT     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KEEP_WIDTH  = (DATA_WIDTH / 8 > 0) ? DATA_WIDTH / 8 : 1,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned MAX_BEATS   = 256,
  parameter int unsigned CL_S_COUNT  = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [CL_S_COUNT-1:0]         m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [S_COUNT-1:0]            grant,
  output logic                          grant_valid
);

  typedef struct packed {
    logic [CL_S_COUNT-1:0] id;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
    logic [KEEP_WIDTH-1:0] keep;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                state_q, state_d;
  logic [S_COUNT-1:0]    grant_q, grant_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [CL_S_COUNT-1:0] gidx_q, gidx_d, ptr_q, ptr_d;
  logic [CL_S_COUNT-1:0] win_idx, cand;
  logic                  path_ready_q;
  logic                  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  beat_t                 out_q, out_d, skid_q, skid_d, in_beat;
  logic                  sel_valid, sel_last, accept, fwd, cut, drop, out_free;

  // Winner search; loops run backwards so the last hit is the first in priority order.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    if (ROUND_ROBIN != 0) begin
      for (int k = S_COUNT; k >= 1; k--) begin
        cand = CL_S_COUNT'((32'(ptr_q) + 32'(k)) % S_COUNT);
        if (s_axis_tvalid[cand]) win_idx = cand;
      end
    end else begin
      for (int k = S_COUNT - 1; k >= 0; k--) begin
        if (s_axis_tvalid[k]) win_idx = CL_S_COUNT'(k);
      end
    end
  end

  assign sel_valid     = s_axis_tvalid[gidx_q];
  assign sel_last      = s_axis_tlast[gidx_q];
  assign accept        = grant_valid_q & sel_valid & (path_ready_q | drop);
  assign fwd           = accept & ~drop;
  assign s_axis_tready = grant_q & {S_COUNT{path_ready_q | drop}};

`ifdef AXIS_ARB_MAXBEAT_EN
  localparam int unsigned CntW = $clog2(MAX_BEATS + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drop_q, drop_d;

  assign drop = drop_q;
  // Truncate an over-long frame: the limit beat becomes a flagged tlast, the rest is swallowed.
  assign cut  = fwd & ~sel_last & (cnt_q == CntW'(MAX_BEATS - 1));

  always_comb begin
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (state_q == StIdle) begin
      cnt_d  = '0;
      drop_d = 1'b0;
    end else if (fwd) begin
      cnt_d = cnt_q + 1'b1;
      if (cut) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end
`else
  logic unused_max_beats;
  assign unused_max_beats = ^MAX_BEATS;
  assign drop = 1'b0;
  assign cut  = 1'b0;
`endif

  always_comb begin
    in_beat.id   = gidx_q;
    in_beat.data = s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    in_beat.keep = s_axis_tkeep[gidx_q*KEEP_WIDTH +: KEEP_WIDTH];
    in_beat.user = s_axis_tuser[gidx_q*USER_WIDTH +: USER_WIDTH];
    in_beat.last = sel_last | cut;
    if (cut) in_beat.user[0] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    gidx_d        = gidx_q;
    ptr_d         = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|s_axis_tvalid) begin
          state_d          = StActive;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_valid_d    = 1'b1;
          gidx_d           = win_idx;
        end
      end
      StActive: begin
        if (accept && sel_last) begin
          state_d       = StIdle;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          ptr_d         = gidx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register plus skid; input ready is registered as "skid empty".
  assign out_free = ~out_valid_q | m_axis_tready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      if (out_free) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (fwd) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_d       = in_beat;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = in_beat;
      end
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      gidx_q        <= '0;
      ptr_q         <= CL_S_COUNT'(S_COUNT - 1);
      path_ready_q  <= 1'b1;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      gidx_q        <= gidx_d;
      ptr_q         <= ptr_d;
      path_ready_q  <= ~skid_valid_d;
      out_valid_q   <= out_valid_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    out_q  <= out_d;
    skid_q <= skid_d;
  end

  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tid    = out_q.id;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tvalid = out_valid_q;
  assign grant         = grant_q;
  assign grant_valid   = grant_valid_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench: dut 0 is round-robin, dut 1 is fixed priority; both use MAX_BEATS=4.
module tb_axis_frame_arbiter;
  localparam int S  = 4;
  localparam int DW = 8;
  localparam int CL = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic m_ready;
  always #5 clk = ~clk;

  logic [S*DW-1:0] s_tdata  [2];
  logic [S-1:0]    s_tkeep  [2];
  logic [S-1:0]    s_tvalid [2];
  logic [S-1:0]    s_tready [2];
  logic [S-1:0]    s_tlast  [2];
  logic [S-1:0]    s_tuser  [2];
  logic [DW-1:0]   m_tdata  [2];
  logic [0:0]      m_tkeep  [2];
  logic            m_tvalid [2];
  logic            m_tlast  [2];
  logic [CL-1:0]   m_tid    [2];
  logic [0:0]      m_tuser  [2];
  logic [S-1:0]    grant    [2];
  logic            grant_valid [2];

  logic [8:0]  smem [2][S][64];
  int          rd [2][S];
  int          wr [2][S];
  logic [12:0] exp0 [$];
  logic [12:0] exp1 [$];
  int          ocyc [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  axis_frame_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(1), .USER_WIDTH(1), .ROUND_ROBIN(1), .MAX_BEATS(4)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_ready), .m_axis_tlast(m_tlast[0]), .m_axis_tid(m_tid[0]),
    .m_axis_tuser(m_tuser[0]), .grant(grant[0]), .grant_valid(grant_valid[0])
  );

  axis_frame_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(1), .USER_WIDTH(1), .ROUND_ROBIN(0), .MAX_BEATS(4)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_ready), .m_axis_tlast(m_tlast[1]), .m_axis_tid(m_tid[1]),
    .m_axis_tuser(m_tuser[1]), .grant(grant[1]), .grant_valid(grant_valid[1])
  );

  // Source models present the head of each per-source beat queue.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      s_tdata[d]  = '0;
      s_tkeep[d]  = '1;
      s_tvalid[d] = '0;
      s_tlast[d]  = '0;
      s_tuser[d]  = '0;
      for (int i = 0; i < S; i++) begin
        if (rd[d][i] != wr[d][i]) begin
          s_tvalid[d][i]         = 1'b1;
          s_tdata[d][i*DW +: DW] = smem[d][i][rd[d][i] % 64][7:0];
          s_tlast[d][i]          = smem[d][i][rd[d][i] % 64][8];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input int d, input int src, input int n, input logic [7:0] base);
    for (int b = 0; b < n; b++) begin
      smem[d][src][wr[d][src] % 64] = {(b == n - 1), base + 8'(b)};
      wr[d][src]++;
    end
  endtask

  task automatic expect_beat(input int d, input int tid, input logic [7:0] data,
                             input logic last, input logic user);
    logic [12:0] e;
    e = {2'(tid), user, last, 1'b1, data};
    if (d == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  task automatic expect_frame(input int d, input int tid, input int n, input logic [7:0] base);
    for (int b = 0; b < n; b++) expect_beat(d, tid, base + 8'(b), (b == n - 1), 1'b0);
  endtask

  function automatic bit all_idle();
    bit r;
    r = (exp0.size() == 0) && (exp1.size() == 0);
    for (int d = 0; d < 2; d++) begin
      if (grant_valid[d] || m_tvalid[d]) r = 1'b0;
      for (int i = 0; i < S; i++) if (rd[d][i] != wr[d][i]) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_idle(input string name, input int maxc);
    int c;
    c = 0;
    while (!all_idle() && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(all_idle()), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Pop a source beat when its handshake was seen in the preceding cycle.
  initial begin : popper
    logic [S-1:0] hs [2];
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) hs[d] = s_tvalid[d] & s_tready[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < S; i++)
          if (hs[d][i] && rst_n) rd[d][i]++;
    end
  end

  initial begin : monitor
    logic [12:0] prev [2];
    bit          stalled [2];
    logic [12:0] act;
    logic [12:0] exp;
    stalled[0] = 1'b0;
    stalled[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          stalled[d] = 1'b0;
        end else begin
          act = {m_tid[d], m_tuser[d], m_tlast[d], m_tkeep[d], m_tdata[d]};
          if (stalled[d]) chk($sformatf("stall_hold%0d", d), {m_tvalid[d], act}, {1'b1, prev[d]});
          if (m_tvalid[d] && m_ready) begin
            if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_beat dut%0d: got %0h expected none", d, act);
            end else begin
              if (d == 0) begin
                exp = exp0.pop_front();
                ocyc.push_back(cyc);
              end else begin
                exp = exp1.pop_front();
              end
              chk($sformatf("beat dut%0d {tid,user,last,keep,data}", d), 32'(act), 32'(exp));
            end
          end
          stalled[d] = m_tvalid[d] && !m_ready;
          prev[d]    = act;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_grant", grant[0], 0);
    chk("rst_grant_valid", grant_valid[0], 0);
    chk("rst_s_tready", s_tready[0], 0);
    chk("rst_m_tvalid", m_tvalid[0], 0);
    chk("rst_fp_grant_valid", grant_valid[1], 0);
    chk("rst_fp_m_tvalid", m_tvalid[1], 0);

    // Single 4-beat frame from source 0: grant in cycle 1, outputs in cycles 2..5.
    @(posedge clk);
    #1;
    load(0, 0, 4, 8'hA0);
    expect_frame(0, 0, 4, 8'hA0);
    @(negedge clk);
    chk("t1_gv_c0", grant_valid[0], 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t1_gv_c%0d", k), grant_valid[0], (k <= 4) ? 1 : 0);
      chk($sformatf("t1_mvalid_c%0d", k), m_tvalid[0], (k >= 2 && k <= 5) ? 1 : 0);
      if (k == 1) chk("t1_grant", grant[0], 4'b0001);
    end
    wait_idle("t1_idle", 50);

    // Three simultaneous 2-beat frames, round-robin from reset pointer.
    do_reset();
    @(posedge clk);
    #1;
    ocyc.delete();
    load(0, 0, 2, 8'h20);
    load(0, 1, 2, 8'h30);
    load(0, 2, 2, 8'h40);
    expect_frame(0, 0, 2, 8'h20);
    expect_frame(0, 1, 2, 8'h30);
    expect_frame(0, 2, 2, 8'h40);
    wait_idle("t2_idle", 60);
    chk("t2_beats", ocyc.size(), 6);
    if (ocyc.size() == 6) begin
      for (int j = 1; j < 6; j++)
        chk($sformatf("t2_gap%0d", j), ocyc[j] - ocyc[j-1], (j % 2 == 1) ? 1 : 2);
    end

    // Fixed priority: source 0 re-requests and keeps winning.
    @(posedge clk);
    #1;
    load(1, 0, 2, 8'h50);
    load(1, 0, 2, 8'h52);
    load(1, 1, 2, 8'h60);
    load(1, 2, 2, 8'h70);
    expect_frame(1, 0, 2, 8'h50);
    expect_frame(1, 0, 2, 8'h52);
    expect_frame(1, 1, 2, 8'h60);
    expect_frame(1, 2, 2, 8'h70);
    wait_idle("t3_idle", 80);

    // Back-pressure toggling every cycle through an 8-beat frame from source 1.
    @(posedge clk);
    #1;
    load(0, 1, 8, 8'h10);
    expect_frame(0, 1, 8, 8'h10);
    for (int k = 0; k < 80 && !all_idle(); k++) begin
      @(posedge clk);
      #1 m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    wait_idle("t4_idle", 50);

    // Reset while the third beat of six is presented.
    @(posedge clk);
    #1;
    load(0, 0, 6, 8'h80);
    expect_frame(0, 0, 6, 8'h80);
    c = 0;
    while (rd[0][0] != wr[0][0] - 4 && c < 50) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk("t5_reached_beat3", wr[0][0] - rd[0][0], 4);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_m_tvalid", m_tvalid[0], 0);
    chk("t5_grant", grant[0], 0);
    chk("t5_grant_valid", grant_valid[0], 0);
    chk("t5_s_tready", s_tready[0], 0);
    exp0.delete();
    rd[0][0] = wr[0][0];
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    load(0, 2, 2, 8'hA8);
    load(0, 0, 2, 8'hB0);
    expect_frame(0, 0, 2, 8'hB0);
    expect_frame(0, 2, 2, 8'hA8);
    c = 0;
    while (!grant_valid[0] && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("t5_first_grant", grant[0], 4'b0001);
    wait_idle("t5_idle", 50);

    // Over-long 7-beat frame followed by a normal 2-beat frame on source 2.
    @(posedge clk);
    #1;
    load(0, 2, 7, 8'hC0);
    load(0, 2, 2, 8'hD0);
`ifdef AXIS_ARB_MAXBEAT_EN
    for (int b = 0; b < 3; b++) expect_beat(0, 2, 8'hC0 + 8'(b), 1'b0, 1'b0);
    expect_beat(0, 2, 8'hC3, 1'b1, 1'b1);
`else
    expect_frame(0, 2, 7, 8'hC0);
`endif
    expect_frame(0, 2, 2, 8'hD0);
    wait_idle("t6_idle", 60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
